// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the raw lines, frames 11-bit words
// and folds the E0/F0 prefixes into a single make/break scan-code event.
module ps2_scan_decoder #(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       Clock_50,
  input  logic       Reset,
  input  logic       PS2_clock,
  input  logic       PS2_data,
  output logic [7:0] PS2_code,
  output logic       PS2_code_ready,
  output logic       PS2_make_code,
  output logic       PS2_extended,
  output logic       PS2_frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FILT_MAX  = FW'(FILTER_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state;
  state_t        next_state;
  logic          clk_meta;
  logic          clk_sync;
  logic          data_meta;
  logic          data_sync;
  logic          filt_level;
  logic          filt_prev;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_bit;
  logic          break_pending;
  logic          ext_pending;
  logic          fall;
  logic          frame_ok;
  logic          frame_good;
  logic          frame_bad;
  logic          timeout;

  assign fall     = filt_prev & ~filt_level;
  assign frame_ok = (^{shift, parity_bit}) & data_sync;

  // State register
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and frame verdicts; a falling edge outranks a simultaneous timeout
  always_comb begin
    next_state = state;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    timeout    = 1'b0;
    if (fall) begin
      case (state)
        S_IDLE: begin
          if (!data_sync) begin
            next_state = S_DATA;
          end else begin
            next_state = S_IDLE;
          end
        end
        S_DATA: begin
          if (bit_cnt == 3'd7) begin
            next_state = S_PARITY;
          end else begin
            next_state = S_DATA;
          end
        end
        S_PARITY: next_state = S_STOP;
        S_STOP: begin
          next_state = S_IDLE;
          if (frame_ok) begin
            frame_good = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end else if (state != S_IDLE && timer == TIMER_MAX) begin
      timeout    = 1'b1;
      next_state = S_IDLE;
    end else begin
      next_state = state;
    end
  end

  // Input conditioning, frame datapath, prefix tracking and registered outputs
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      clk_meta        <= 1'b1;
      clk_sync        <= 1'b1;
      data_meta       <= 1'b1;
      data_sync       <= 1'b1;
      filt_level      <= 1'b1;
      filt_prev       <= 1'b1;
      filt_cnt        <= '0;
      timer           <= '0;
      bit_cnt         <= 3'd0;
      shift           <= 8'h00;
      parity_bit      <= 1'b0;
      break_pending   <= 1'b0;
      ext_pending     <= 1'b0;
      PS2_code        <= 8'h00;
      PS2_code_ready  <= 1'b0;
      PS2_make_code   <= 1'b0;
      PS2_extended    <= 1'b0;
      PS2_frame_error <= 1'b0;
    end else begin
      clk_meta  <= PS2_clock;
      clk_sync  <= clk_meta;
      data_meta <= PS2_data;
      data_sync <= data_meta;
      filt_prev <= filt_level;

      // The level flips only after FILTER_LEN consecutive disagreeing samples
      if (clk_sync != filt_level) begin
        if (filt_cnt == FILT_MAX) begin
          filt_level <= clk_sync;
          filt_cnt   <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end

      if (state == S_IDLE || fall || timeout) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      if (state == S_IDLE) begin
        bit_cnt <= 3'd0;
      end else if (fall && state == S_DATA) begin
        shift   <= {data_sync, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end else begin
        bit_cnt <= bit_cnt;
      end

      if (fall && state == S_PARITY) begin
        parity_bit <= data_sync;
      end else begin
        parity_bit <= parity_bit;
      end

      PS2_code_ready  <= 1'b0;
      PS2_frame_error <= 1'b0;
      if (frame_good) begin
        if (shift == 8'hF0) begin
          break_pending <= 1'b1;
        end else if (shift == 8'hE0) begin
          ext_pending <= 1'b1;
        end else begin
          PS2_code       <= shift;
          PS2_make_code  <= ~break_pending;
          PS2_extended   <= ext_pending;
          PS2_code_ready <= 1'b1;
          break_pending  <= 1'b0;
          ext_pending    <= 1'b0;
        end
      end else if (frame_bad || timeout) begin
        PS2_frame_error <= 1'b1;
        break_pending   <= 1'b0;
        ext_pending     <= 1'b0;
      end else begin
        break_pending <= break_pending;
        ext_pending   <= ext_pending;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: a key-event model predicts every ready/error
// pulse and the held code, checked each cycle, plus literal pins after each scenario.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] code;
  logic       ready;
  logic       make;
  logic       ext;
  logic       ferr;

  typedef struct {
    bit       is_err;
    bit [7:0] code;
    bit       make;
    bit       ext;
  } event_t;

  event_t   exp_q[$];
  int       checks = 0;
  int       errors = 0;
  bit       m_brk = 1'b0;
  bit       m_ext = 1'b0;
  bit [7:0] m_code = 8'h00;
  bit       m_make = 1'b0;
  bit       m_xt = 1'b0;

  ps2_scan_decoder dut (
    .Clock_50(clk), .Reset(rst), .PS2_clock(ps2_clk), .PS2_data(ps2_dat),
    .PS2_code(code), .PS2_code_ready(ready), .PS2_make_code(make),
    .PS2_extended(ext), .PS2_frame_error(ferr)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the first n bits of an 11-bit PS/2 word, bit 0 first
  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      wait_cyc(10);
      ps2_clk = 1'b0;
      wait_cyc(20);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    ps2_dat = 1'b1;
  endtask

  function automatic logic [10:0] word(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  // Key-event model: a good byte either arms a prefix or produces one event
  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    event_t e;
    if (bad_par) begin
      e = '{1'b1, 8'h00, 1'b0, 1'b0};
      exp_q.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      e = '{1'b0, b, ~m_brk, m_ext};
      exp_q.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    ps2_bits(word(b, bad_par), 11);
    check("pulse_by_frame_end", exp_q.size(), 0);
  endtask

  task automatic pin(input string name, input logic [7:0] c, input logic mk, input logic x);
    check({name, "_code"}, code, c);
    check({name, "_make"}, make, mk);
    check({name, "_ext"}, ext, x);
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    event_t e;
    if (rst) begin
      m_code = 8'h00;
      m_make = 1'b0;
      m_xt   = 1'b0;
    end else begin
      check("ready_and_error", {ready, ferr} == 2'b11, 0);
      if (ready === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].is_err) begin
          check("unexpected_ready", 1, 0);
        end else begin
          e = exp_q.pop_front();
          m_code = e.code;
          m_make = e.make;
          m_xt   = e.ext;
        end
      end
      if (ferr === 1'b1) begin
        if (exp_q.size() == 0 || !exp_q[0].is_err) begin
          check("unexpected_error", 1, 0);
        end else begin
          e = exp_q.pop_front();
        end
      end
      check("held_outputs", {code, make, ext}, {m_code, m_make, m_xt});
    end
  end

  initial begin
    event_t e;
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(2);
    pin("reset", 8'h00, 1'b0, 1'b0);
    check("reset_ready", ready, 0);
    check("reset_error", ferr, 0);

    send_frame(8'h1C, 1'b0);
    pin("make_1c", 8'h1C, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    pin("break_1c", 8'h1C, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    pin("ext_make_75", 8'h75, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    pin("ext_break_75", 8'h75, 1'b0, 1'b1);

    send_frame(8'h1C, 1'b1);
    pin("after_parity_err", 8'h75, 1'b0, 1'b1);

    // Stalled partial frame must abort with one error pulse
    e = '{1'b1, 8'h00, 1'b0, 1'b0};
    ps2_bits(word(8'h1C, 1'b0), 5);
    exp_q.push_back(e);
    wait_cyc(10100);
    check("timeout_error_seen", exp_q.size(), 0);
    send_frame(8'h1C, 1'b0);
    pin("after_timeout", 8'h1C, 1'b1, 1'b0);

    // Two-cycle glitch with data low must not start a frame
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(3);
    ps2_dat = 1'b1;
    wait_cyc(50);
    send_frame(8'hF0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    pin("double_f0", 8'h1C, 1'b0, 1'b0);

    // Reset mid-frame drops the partial frame and the pending break prefix
    send_frame(8'hF0, 1'b0);
    ps2_bits(word(8'h2A, 1'b0), 5);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
    wait_cyc(1);
    pin("mid_reset", 8'h00, 1'b0, 1'b0);
    check("mid_reset_ready", ready, 0);
    check("mid_reset_error", ferr, 0);
    send_frame(8'h1C, 1'b0);
    pin("post_reset_1c", 8'h1C, 1'b1, 1'b0);

    wait_cyc(20);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
